// File: rtl/keypad_scanner_if.sv
// Key-event bus from the keypad scanner to its consumer (for example the hex display driver).
// The master drives the accepted key code, strobe, held flag and 16-bit nibble history.
interface keypad_scanner_if;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] key_hist;

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        output key_hist
    );

    modport slave (
        input key_code,
        input key_valid,
        input key_held,
        input key_hist
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column scan, 2-flop row synchronizer, press/release debounce, key strobe.
// Optional macro KEYPAD_HISTORY_EN keeps a four-key nibble history; otherwise KEY_HIST = {12'h000, code}.
module keypad_scanner #(
    parameter logic [15:0] SCAN_DIV       = 16'd50000,
    parameter logic [3:0]  DEBOUNCE_SCANS = 4'd8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       row_i,
    output logic [3:0]       col_o,
    keypad_scanner_if.master key_if
);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [3:0]  row_meta_q, rs_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  row_idx_q, row_idx_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d;
    logic        key_held_q, key_held_d;
`ifdef KEYPAD_HISTORY_EN
    logic [15:0] hist_q, hist_d;
`endif

    logic        tick;
    logic        any_low;
    logic [1:0]  low_idx;
    logic        latched_low;
    logic        lower_clear;
    logic        row_match;
    logic [3:0]  cnt_inc;
    logic        cnt_last;
    logic        one_scan;
    logic [1:0]  code_row;
    logic [3:0]  lower_mask;

    // Action flags handed from the next-state process to the datapath process.
    logic        act_accept, act_rotate, act_latch, act_cnt_one, act_cnt_step, act_release;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        unique case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            4'b11_11: code = 4'hD;
        endcase
        return code;
    endfunction

    assign tick     = (presc_q == SCAN_DIV - 16'd1);
    assign any_low  = (rs_q != 4'hF);
    assign one_scan = (DEBOUNCE_SCANS <= 4'd1);
    assign cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    assign cnt_last = (cnt_inc >= DEBOUNCE_SCANS);

    always_comb begin
        low_idx = 2'd3;
        if (!rs_q[0])      low_idx = 2'd0;
        else if (!rs_q[1]) low_idx = 2'd1;
        else if (!rs_q[2]) low_idx = 2'd2;
    end

    // A press only keeps counting while it is still the lowest low row in the frozen column.
    assign lower_mask  = (4'b0001 << row_idx_q) - 4'd1;
    assign latched_low = ~rs_q[row_idx_q];
    assign lower_clear = ((~rs_q & lower_mask) == 4'h0);
    assign row_match   = latched_low && lower_clear;
    assign code_row    = (state_q == ST_SCAN) ? low_idx : row_idx_q;

    // State register (all sequential state).
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q     <= ST_SCAN;
            presc_q     <= 16'd0;
            row_meta_q  <= 4'hF;
            rs_q        <= 4'hF;
            cnt_q       <= 4'd0;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_HISTORY_EN
            // NOTE: the history is a plain register, so it is reset with everything else.
            hist_q      <= 16'h0000;
`endif
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            row_meta_q  <= row_i;
            rs_q        <= row_meta_q;
            cnt_q       <= cnt_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_HISTORY_EN
            hist_q      <= hist_d;
`endif
        end
    end

    // Next-state process: FSM decisions happen only on scan ticks.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_d      = state_q;
        act_accept   = 1'b0;
        act_rotate   = 1'b0;
        act_latch    = 1'b0;
        act_cnt_one  = 1'b0;
        act_cnt_step = 1'b0;
        act_release  = 1'b0;
        if (tick) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (any_low) begin
                        act_latch = 1'b1;
                        if (one_scan) begin
                            act_accept = 1'b1;
                            state_d    = ST_HELD;
                        end else begin
                            act_cnt_one = 1'b1;
                            state_d     = ST_DEBOUNCE;
                        end
                    end else begin
                        act_rotate = 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_match) begin
                        act_cnt_step = 1'b1;
                        if (cnt_last) begin
                            act_accept = 1'b1;
                            state_d    = ST_HELD;
                        end
                    end else begin
                        act_rotate = 1'b1;
                        state_d    = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (!latched_low) begin
                        if (one_scan) begin
                            act_release = 1'b1;
                            act_rotate  = 1'b1;
                            state_d     = ST_SCAN;
                        end else begin
                            act_cnt_one = 1'b1;
                            state_d     = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!latched_low) begin
                        act_cnt_step = 1'b1;
                        if (cnt_last) begin
                            act_release = 1'b1;
                            act_rotate  = 1'b1;
                            state_d     = ST_SCAN;
                        end
                    end else begin
                        state_d = ST_HELD;
                    end
                end
            endcase
        end
    end

    // Output / datapath process.
    always_comb begin
        presc_d     = tick ? 16'd0 : presc_q + 16'd1;
        cnt_d       = cnt_q;
        row_idx_d   = act_latch ? low_idx : row_idx_q;
        col_idx_d   = act_rotate ? col_idx_q + 2'd1 : col_idx_q;
        key_code_d  = key_code_q;
        key_valid_d = act_accept;
        key_held_d  = key_held_q;
        if (act_cnt_one)       cnt_d = 4'd1;
        else if (act_cnt_step) cnt_d = cnt_inc;
        if (act_accept) begin
            key_code_d = key_map(code_row, col_idx_q);
            key_held_d = 1'b1;
        end else if (act_release) begin
            key_held_d = 1'b0;
        end
`ifdef KEYPAD_HISTORY_EN
        hist_d = hist_q;
        if (act_accept) hist_d = {hist_q[11:0], key_map(code_row, col_idx_q)};
`endif
    end

    assign col_o            = ~(4'b0001 << col_idx_q);
    assign key_if.key_code  = key_code_q;
    assign key_if.key_valid = key_valid_q;
    assign key_if.key_held  = key_held_q;
`ifdef KEYPAD_HISTORY_EN
    assign key_if.key_hist  = hist_q;
`else
    assign key_if.key_hist  = {12'h000, key_code_q};
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized scoreboard bench for keypad_scanner with a keypad contact model (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// Stimulus pushes expected key codes; an independent monitor pops and compares on every strobe.
module tb_keypad_scanner;

    localparam logic [15:0] SCAN_DIV       = 16'd4;
    localparam logic [3:0]  DEBOUNCE_SCANS = 4'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] pressed = 16'h0000;
    logic        bounce_open = 1'b0;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    logic [3:0]  exp_q[$];
    logic [15:0] exp_hist = 16'h0000;
    logic        prev_valid = 1'b0;

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .row_i  (row),
        .col_o  (col),
        .key_if (kif)
    );

    always #5 clk = ~clk;

    // Keypad: a closed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c] && !bounce_open) row[r] = 1'b0;
    end

    function automatic logic [3:0] ref_code(input int r, input int c);
        logic [63:0] keys;
        keys = 64'h123A_456B_789C_0FED;
        return keys[63 - 4*(r*4+c) -: 4];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && kif.key_valid) begin
            strobe_cnt++;
            check("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
            check("valid_pulse_width", 32'(prev_valid), 32'd0);
            if (exp_q.size() > 0) begin
                logic [3:0] e;
                e = exp_q.pop_front();
`ifdef KEYPAD_HISTORY_EN
                exp_hist = {exp_hist[11:0], e};
`else
                exp_hist = {12'h000, e};
`endif
                check("key_code", 32'(kif.key_code), 32'(e));
                check("key_hist", 32'(kif.key_hist), 32'(exp_hist));
                check("held_at_strobe", 32'(kif.key_held), 32'd1);
            end
        end
        prev_valid = rst ? 1'b0 : kif.key_valid;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int r, input int c);
        pressed[r*4+c] = 1'b1;
        exp_q.push_back(ref_code(r, c));
    endtask

    task automatic release_key(input int r, input int c);
        pressed[r*4+c] = 1'b0;
    endtask

    task automatic wait_held(input logic val, input int budget, input string name);
        int n = 0;
        while (kif.key_held !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(kif.key_held), 32'(val));
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    // Waits for COL to switch to the given value, so the caller starts right after a tick.
    task automatic wait_col_enter(input logic [3:0] val);
        int n = 0;
        while (col === val && n < 80) begin @(negedge clk); n++; end
        while (col !== val && n < 80) begin @(negedge clk); n++; end
        check("col_reached", 32'(col), 32'(val));
    endtask

    initial begin
        logic [3:0] prev;
        int n;
        int base;

        // Reset state.
        cycles(2);
        check("rst_col", 32'(col), 32'h0000_000E);
        check("rst_code", 32'(kif.key_code), 32'd0);
        check("rst_valid", 32'(kif.key_valid), 32'd0);
        check("rst_held", 32'(kif.key_held), 32'd0);
        check("rst_hist", 32'(kif.key_hist), 32'd0);
        rst = 1'b0;

        // Idle scan: one rotation every SCAN_DIV cycles.
        prev = col;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (col === prev && n < 12) begin @(negedge clk); n++; end
            check("col_rotate", 32'(col), 32'({prev[2:0], prev[3]}));
            if (i > 0) check("col_period", 32'(n), 32'(SCAN_DIV));
            prev = col;
        end

        // Clean press r1,c2 held 200 cycles.
        base = strobe_cnt;
        press(1, 2);
        cycles(200);
        check("clean_strobe_count", 32'(strobe_cnt - base), 32'd1);
        check("clean_held", 32'(kif.key_held), 32'd1);
        check("clean_code", 32'(kif.key_code), 32'h6);
        release_key(1, 2);
        wait_held(1'b0, 40, "clean_release");
        prev = col;
        n = 0;
        while (col === prev && n < 12) begin @(negedge clk); n++; end
        check("scan_resumes", 32'(col), 32'({prev[2:0], prev[3]}));

        // Bouncing press r3,c1: one tick closed, one tick open, then stable.
        wait_col_enter(4'b1101);
        base = strobe_cnt;
        press(3, 1);
        cycles(4);
        bounce_open = 1'b1;
        cycles(4);
        bounce_open = 1'b0;
        check("bounce_no_strobe", 32'(strobe_cnt - base), 32'd0);
        wait_drain(120, "bounce_strobe");
        check("bounce_strobe_count", 32'(strobe_cnt - base), 32'd1);
        cycles(40);
        release_key(3, 1);
        wait_held(1'b0, 40, "bounce_release");

        // Two keys together: first accepted wins, second follows after release.
        wait_col_enter(4'b1110);
        press(0, 0);
        pressed[2*4+3] = 1'b1;
        wait_drain(60, "multi_first");
        cycles(60);
        check("multi_code_kept", 32'(kif.key_code), 32'h1);
        exp_q.push_back(ref_code(2, 3));
        release_key(0, 0);
        wait_drain(120, "multi_second");
        cycles(20);
        release_key(2, 3);
        wait_held(1'b0, 40, "multi_release");

        // History: 1, 2, 3, A in turn.
        for (int c = 0; c < 4; c++) begin
            press(0, c);
            wait_drain(80, "hist_press");
            cycles(30);
            release_key(0, c);
            wait_held(1'b0, 40, "hist_release");
            cycles(10);
        end
`ifdef KEYPAD_HISTORY_EN
        check("hist_final", 32'(kif.key_hist), 32'h0000_123A);
`else
        check("hist_final", 32'(kif.key_hist), 32'h0000_000A);
`endif

        // Reset pulse while a key is held: re-detected from scratch.
        press(2, 1);
        wait_drain(80, "rst_press");
        cycles(20);
        check("rst_pre_held", 32'(kif.key_held), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_hist = 16'h0000;
        check("rstmid_col", 32'(col), 32'h0000_000E);
        check("rstmid_code", 32'(kif.key_code), 32'd0);
        check("rstmid_held", 32'(kif.key_held), 32'd0);
        check("rstmid_hist", 32'(kif.key_hist), 32'd0);
        base = strobe_cnt;
        exp_q.push_back(ref_code(2, 1));
        wait_drain(80, "rst_redetect");
        check("rst_redetect_count", 32'(strobe_cnt - base), 32'd1);
        release_key(2, 1);
        wait_held(1'b0, 40, "rst_release");

        // Randomized single presses.
        for (int i = 0; i < 12; i++) begin
            int r, c;
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            cycles($urandom_range(1, 20));
            press(r, c);
            wait_drain(80, "rand_strobe");
            cycles($urandom_range(20, 120));
            check("rand_code", 32'(kif.key_code), 32'(ref_code(r, c)));
            release_key(r, c);
            wait_held(1'b0, 40, "rand_release");
        end

        cycles(20);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
